mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and the execute stage's load/store path.
- The execute stage supplies a raw store word plus funct3. The arbiter builds byte strobes and aligns the write data, and on loads it right-justifies the returned word. Sign and zero extension stay in execute.
- One outstanding memory transaction at a time; registered handshake on both sides.

Parameters:
- XLEN, 32, datapath/address width (from shared package; only 32 supported)

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous active-low reset
- if_req_valid  in  1  fetch request; held stable until if_resp_valid
- if_req_addr  in  XLEN  fetch PC
- if_resp_valid  out  1  one-cycle completion pulse for fetch
- if_resp_data  out  XLEN  instruction word
- if_misaligned  out  1  qualifies if_resp_valid: PC[1:0]!=0, no access made
- d_req_valid  in  1  data request; held stable until d_resp_valid
- d_req_we  in  1  1=store, 0=load
- d_req_addr  in  XLEN  effective address
- d_req_funct3  in  3  LB/LH/LW/LBU/LHU or SB/SH/SW encoding
- d_req_wdata  in  XLEN  raw rs2 value (unshifted)
- d_resp_valid  out  1  one-cycle completion pulse for data
- d_resp_data  out  XLEN  load data shifted right by 8*addr[1:0], upper bits raw; 0 for stores
- d_misaligned  out  1  qualifies d_resp_valid: misaligned or illegal funct3, no access made
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts request when valid&&ready
- mem_req_addr  out  XLEN  word address {addr[31:2],2'b00}
- mem_req_we  out  1  write enable
- mem_req_wstrb  out  4  byte strobes
- mem_req_wdata  out  XLEN  lane-aligned write data
- mem_resp_valid  in  1  one pulse per accepted request, including writes
- mem_resp_rdata  in  XLEN  read word

Behaviour:
- All outputs are registered.
- Reset values: state=IDLE, last_grant=FETCH, all valids/pulses/flags 0, data/addr buses 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE, grant selection:
  - Only data valid: grant data. Only fetch valid: grant fetch.
  - Both valid: grant data unless last_grant==DATA, in which case grant fetch.
  - On grant, record last_grant and latch the granted request.
- IDLE, next state:
  - Granted request is legal: drive mem_req_* from the next cycle and go to REQ.
  - Granted request is illegal: go directly to RESP with the misaligned flag set. No memory request is made.
- Illegal requests:
  - Fetch with addr[1:0]!=0.
  - Data LH/LHU/SH with addr[0]=1.
  - Data LW/SW with addr[1:0]!=0.
  - funct3 not in the legal set for the given we.
- REQ: hold mem_req_valid and all fields stable. On mem_req_ready, drop mem_req_valid the next cycle and go to WAIT.
- WAIT: on mem_resp_valid, latch rdata (shifted for data loads) and go to RESP.
  - mem_resp_valid arriving in IDLE, REQ or RESP is ignored.
- RESP: pulse exactly one of if_resp_valid / d_resp_valid for one cycle, then go to IDLE.
  - The requester may drop valid or present a new request on the cycle after the pulse.
  - IDLE never re-samples during RESP, so no duplicate issue is possible.
- Store lane formation:
  - SB: wstrb = 4'b0001<<addr[1:0], wdata = {4{wdata[7:0]}}.
  - SH: wstrb = 4'b0011<<addr[1:0], wdata = {2{wdata[15:0]}}.
  - SW: wstrb = 4'b1111, wdata passes through.
- Loads: wstrb=0. d_resp_data = rdata >> 8*addr[1:0].
- Minimum latency: request in cycle N -> mem_req_valid at N+1 -> if ready at N+1 and resp at N+2, pulse at N+3. Illegal request: pulse at N+1.
- Reset mid-operation: immediate return to IDLE. The in-flight transaction is abandoned, and a late mem_resp_valid is ignored because it arrives outside WAIT.
- No combinational path exists from any input to any output.

Decomposition:
- Shared isa package: XLEN, FUNCT3_LB/LH/LW/LBU/LHU/SB/SH/SW constants, a new mem_grant_t enum {FETCH, DATA}, and a mem_arb_state_t enum.
- One combinational sub-module, store_lane_align, covers strobe/wdata formation and the legality check for data requests. It is reused by the load shifter's legality decode.

Test Plan:
- Fetch only, addr 0x100, mem ready immediately, resp rdata 0x00500093 next cycle -> mem_req_addr 0x100, we=0; if_resp_valid pulse at N+3 with data 0x00500093, if_misaligned=0.
- SB addr 0x203, wdata 0x123456AB -> mem_req_addr 0x200, wstrb 4'b1000, wdata 0xABABABAB, we=1; d_resp_valid after the mem resp.
- LHU addr 0x402, rdata 0xBEEF1234 -> d_resp_data[15:0]=0xBEEF. LW addr 0x402 -> d_misaligned pulse at N+1, mem_req_valid never asserted.
- Fetch and data both held valid across three grants -> grant order DATA, FETCH, DATA; mem_req_ready held low 5 cycles keeps every mem_req_* field stable.
- reset_n low while in WAIT, then stray mem_resp_valid -> all outputs 0, no resp pulse, next request issues normally.
- SW addr 0x10 with mem_resp_valid spuriously asserted during REQ -> ignored; exactly one d_resp_valid after the genuine resp.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_pkg
// Description : Shared ISA constants and arbiter types for the memory port.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_port_arbiter_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } mem_grant_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } mem_arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_store_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : store_lane_align
// Description : Data-request legality decode plus store strobe/lane formation.
// Revision    : 1.0 - initial release
// ============================================================================
module store_lane_align
    import mem_port_arbiter_pkg::*;
(
    input  logic            i_we,
    input  logic [1:0]      i_addr_lo,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_wdata,
    output logic [3:0]      o_wstrb,
    output logic [XLEN-1:0] o_wdata,
    output logic            o_legal
);

    logic w_f3_ok;
    logic w_aligned;

    always_comb begin
        w_f3_ok   = 1'b0;
        w_aligned = 1'b0;
        o_wstrb   = 4'b0000;
        o_wdata   = '0;
        if (i_we) begin
            case (i_funct3)
                FUNCT3_SB: begin
                    w_f3_ok   = 1'b1;
                    w_aligned = 1'b1;
                    o_wstrb   = 4'b0001 << i_addr_lo;
                    o_wdata   = {4{i_wdata[7:0]}};
                end
                FUNCT3_SH: begin
                    w_f3_ok   = 1'b1;
                    w_aligned = ~i_addr_lo[0];
                    o_wstrb   = 4'b0011 << i_addr_lo;
                    o_wdata   = {2{i_wdata[15:0]}};
                end
                FUNCT3_SW: begin
                    w_f3_ok   = 1'b1;
                    w_aligned = (i_addr_lo == 2'b00);
                    o_wstrb   = 4'b1111;
                    o_wdata   = i_wdata;
                end
                default: ;
            endcase
        end else begin
            // Loads never write: strobes and write data stay zero.
            case (i_funct3)
                FUNCT3_LB, FUNCT3_LBU: begin
                    w_f3_ok   = 1'b1;
                    w_aligned = 1'b1;
                end
                FUNCT3_LH, FUNCT3_LHU: begin
                    w_f3_ok   = 1'b1;
                    w_aligned = ~i_addr_lo[0];
                end
                FUNCT3_LW: begin
                    w_f3_ok   = 1'b1;
                    w_aligned = (i_addr_lo == 2'b00);
                end
                default: ;
            endcase
        end
        o_legal = w_f3_ok & w_aligned;
    end

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and load/store.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_if_req_valid,
    input  logic [XLEN-1:0] i_if_req_addr,
    output logic            o_if_resp_valid,
    output logic [XLEN-1:0] o_if_resp_data,
    output logic            o_if_misaligned,
    input  logic            i_d_req_valid,
    input  logic            i_d_req_we,
    input  logic [XLEN-1:0] i_d_req_addr,
    input  logic [2:0]      i_d_req_funct3,
    input  logic [XLEN-1:0] i_d_req_wdata,
    output logic            o_d_resp_valid,
    output logic [XLEN-1:0] o_d_resp_data,
    output logic            o_d_misaligned,
    output logic            o_mem_req_valid,
    input  logic            i_mem_req_ready,
    output logic [XLEN-1:0] o_mem_req_addr,
    output logic            o_mem_req_we,
    output logic [3:0]      o_mem_req_wstrb,
    output logic [XLEN-1:0] o_mem_req_wdata,
    input  logic            i_mem_resp_valid,
    input  logic [XLEN-1:0] i_mem_resp_rdata
);

    mem_arb_state_t  r_state;
    mem_arb_state_t  w_state_nxt;
    mem_grant_t      r_last_grant;
    logic            r_we;
    logic [1:0]      r_addr_lo;

    logic            r_mem_req_valid;
    logic [XLEN-1:0] r_mem_req_addr;
    logic            r_mem_req_we;
    logic [3:0]      r_mem_req_wstrb;
    logic [XLEN-1:0] r_mem_req_wdata;
    logic            r_if_resp_valid;
    logic [XLEN-1:0] r_if_resp_data;
    logic            r_if_misaligned;
    logic            r_d_resp_valid;
    logic [XLEN-1:0] r_d_resp_data;
    logic            r_d_misaligned;

    logic            w_grant_any;
    logic            w_grant_data;
    logic            w_req_legal;
    logic [XLEN-1:0] w_gnt_addr;
    logic [3:0]      w_d_wstrb;
    logic [XLEN-1:0] w_d_wdata;
    logic            w_d_legal;
    logic [XLEN-1:0] w_load_data;

    store_lane_align u_store_lane_align (
        .i_we      (i_d_req_we),
        .i_addr_lo (i_d_req_addr[1:0]),
        .i_funct3  (i_d_req_funct3),
        .i_wdata   (i_d_req_wdata),
        .o_wstrb   (w_d_wstrb),
        .o_wdata   (w_d_wdata),
        .o_legal   (w_d_legal)
    );

    assign w_gnt_addr  = w_grant_data ? i_d_req_addr : i_if_req_addr;
    assign w_load_data = i_mem_resp_rdata >> {r_addr_lo, 3'b000};

    // Data wins a tie unless it also won the previous grant.
    always_comb begin
        w_state_nxt  = r_state;
        w_grant_any  = 1'b0;
        w_grant_data = 1'b0;
        w_req_legal  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant_any  = i_d_req_valid | i_if_req_valid;
                w_grant_data = i_d_req_valid &
                               (~i_if_req_valid | (r_last_grant != GRANT_DATA));
                w_req_legal  = w_grant_data ? w_d_legal : (i_if_req_addr[1:0] == 2'b00);
                if (w_grant_any) begin
                    w_state_nxt = w_req_legal ? ST_REQ : ST_RESP;
                end
            end
            ST_REQ: begin
                if (i_mem_req_ready) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (i_mem_resp_valid) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant    <= GRANT_FETCH;
            r_we            <= 1'b0;
            r_addr_lo       <= 2'b00;
            r_mem_req_valid <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_we    <= 1'b0;
            r_mem_req_wstrb <= 4'b0000;
            r_mem_req_wdata <= '0;
            r_if_resp_valid <= 1'b0;
            r_if_resp_data  <= '0;
            r_if_misaligned <= 1'b0;
            r_d_resp_valid  <= 1'b0;
            r_d_resp_data   <= '0;
            r_d_misaligned  <= 1'b0;
        end else begin
            r_if_resp_valid <= 1'b0;
            r_if_misaligned <= 1'b0;
            r_d_resp_valid  <= 1'b0;
            r_d_misaligned  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        r_last_grant <= w_grant_data ? GRANT_DATA : GRANT_FETCH;
                        r_we         <= w_grant_data & i_d_req_we;
                        r_addr_lo    <= w_gnt_addr[1:0];
                        if (w_req_legal) begin
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_addr  <= {w_gnt_addr[XLEN-1:2], 2'b00};
                            r_mem_req_we    <= w_grant_data & i_d_req_we;
                            r_mem_req_wstrb <= w_grant_data ? w_d_wstrb : 4'b0000;
                            r_mem_req_wdata <= w_grant_data ? w_d_wdata : '0;
                        end else if (w_grant_data) begin
                            r_d_resp_valid <= 1'b1;
                            r_d_misaligned <= 1'b1;
                            r_d_resp_data  <= '0;
                        end else begin
                            r_if_resp_valid <= 1'b1;
                            r_if_misaligned <= 1'b1;
                            r_if_resp_data  <= '0;
                        end
                    end
                end
                ST_REQ: begin
                    if (i_mem_req_ready) begin
                        r_mem_req_valid <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (i_mem_resp_valid) begin
                        if (r_last_grant == GRANT_DATA) begin
                            r_d_resp_valid <= 1'b1;
                            r_d_resp_data  <= r_we ? '0 : w_load_data;
                        end else begin
                            r_if_resp_valid <= 1'b1;
                            r_if_resp_data  <= i_mem_resp_rdata;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_mem_req_valid = r_mem_req_valid;
    assign o_mem_req_addr  = r_mem_req_addr;
    assign o_mem_req_we    = r_mem_req_we;
    assign o_mem_req_wstrb = r_mem_req_wstrb;
    assign o_mem_req_wdata = r_mem_req_wdata;
    assign o_if_resp_valid = r_if_resp_valid;
    assign o_if_resp_data  = r_if_resp_data;
    assign o_if_misaligned = r_if_misaligned;
    assign o_d_resp_valid  = r_d_resp_valid;
    assign o_d_resp_data   = r_d_resp_data;
    assign o_d_misaligned  = r_d_misaligned;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Self-checking bench: vector table, corner sequences, random.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_if_req_valid;
    logic [31:0] i_if_req_addr;
    logic        o_if_resp_valid;
    logic [31:0] o_if_resp_data;
    logic        o_if_misaligned;
    logic        i_d_req_valid;
    logic        i_d_req_we;
    logic [31:0] i_d_req_addr;
    logic [2:0]  i_d_req_funct3;
    logic [31:0] i_d_req_wdata;
    logic        o_d_resp_valid;
    logic [31:0] o_d_resp_data;
    logic        o_d_misaligned;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic [31:0] o_mem_req_addr;
    logic        o_mem_req_we;
    logic [3:0]  o_mem_req_wstrb;
    logic [31:0] o_mem_req_wdata;
    logic        i_mem_resp_valid;
    logic [31:0] i_mem_resp_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_if_req_valid   (i_if_req_valid),
        .i_if_req_addr    (i_if_req_addr),
        .o_if_resp_valid  (o_if_resp_valid),
        .o_if_resp_data   (o_if_resp_data),
        .o_if_misaligned  (o_if_misaligned),
        .i_d_req_valid    (i_d_req_valid),
        .i_d_req_we       (i_d_req_we),
        .i_d_req_addr     (i_d_req_addr),
        .i_d_req_funct3   (i_d_req_funct3),
        .i_d_req_wdata    (i_d_req_wdata),
        .o_d_resp_valid   (o_d_resp_valid),
        .o_d_resp_data    (o_d_resp_data),
        .o_d_misaligned   (o_d_misaligned),
        .o_mem_req_valid  (o_mem_req_valid),
        .i_mem_req_ready  (i_mem_req_ready),
        .o_mem_req_addr   (o_mem_req_addr),
        .o_mem_req_we     (o_mem_req_we),
        .o_mem_req_wstrb  (o_mem_req_wstrb),
        .o_mem_req_wdata  (o_mem_req_wdata),
        .i_mem_resp_valid (i_mem_resp_valid),
        .i_mem_resp_rdata (i_mem_resp_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          rdy_dly;
        int          resp_dly;
        logic        spur;
        logic        exp_mis;
        logic [3:0]  exp_strb;
        logic [31:0] exp_wdata;
        logic [31:0] exp_resp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        check({name, "_valids"}, {o_mem_req_valid, o_if_resp_valid, o_d_resp_valid,
                                  o_if_misaligned, o_d_misaligned, o_mem_req_we}, 0);
        check({name, "_addr"},  o_mem_req_addr, 0);
        check({name, "_wstrb"}, o_mem_req_wstrb, 0);
        check({name, "_wdata"}, o_mem_req_wdata, 0);
        check({name, "_ifdat"}, o_if_resp_data, 0);
        check({name, "_ddat"},  o_d_resp_data, 0);
    endtask

    task automatic drop_all();
        i_if_req_valid   = 1'b0;
        i_d_req_valid    = 1'b0;
        i_mem_req_ready  = 1'b0;
        i_mem_resp_valid = 1'b0;
    endtask

    // Reference: access size from funct3, legality by natural alignment,
    // lanes by replicating the low bytes, loads right-justified.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int   size;
        int   lo;
        logic f3ok;
        r  = v;
        lo = int'(v.addr[1:0]);
        if (!v.is_data) begin
            size = 4;
            f3ok = 1'b1;
        end else begin
            f3ok = v.we ? (v.f3 <= 3'd2) : ((v.f3 != 3'd3) && (v.f3 <= 3'd5));
            size = 1 << v.f3[1:0];
        end
        r.exp_mis   = !(f3ok && (lo % size == 0));
        r.exp_strb  = 4'b0000;
        r.exp_wdata = 32'h0;
        r.exp_resp  = 32'h0;
        if (!r.exp_mis) begin
            if (v.is_data && v.we) begin
                r.exp_strb = 4'(((1 << size) - 1) << lo);
                for (int b = 0; b < 4; b++) r.exp_wdata[8*b +: 8] = v.wdata[8*(b % size) +: 8];
            end else begin
                r.exp_resp = v.rdata >> (8 * lo);
            end
        end
        return r;
    endfunction

    task automatic txn(input vec_t v);
        int          cyc;
        int          phase;
        int          cnt;
        int          exp_lat;
        logic        done;
        logic        issued;
        logic [31:0] exp_addr;
        exp_addr = {v.addr[31:2], 2'b00};
        exp_lat  = v.exp_mis ? 1 : 3 + v.rdy_dly + v.resp_dly;
        if (v.is_data) begin
            i_d_req_valid  = 1'b1;
            i_d_req_we     = v.we;
            i_d_req_addr   = v.addr;
            i_d_req_funct3 = v.f3;
            i_d_req_wdata  = v.wdata;
        end else begin
            i_if_req_valid = 1'b1;
            i_if_req_addr  = v.addr;
        end
        cyc = 0; phase = 0; cnt = 0; done = 1'b0; issued = 1'b0;
        while (!done && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            i_mem_req_ready  = 1'b0;
            i_mem_resp_valid = 1'b0;
            if (o_if_resp_valid || o_d_resp_valid) begin
                check("resp_sel", {o_if_resp_valid, o_d_resp_valid}, v.is_data ? 2'b01 : 2'b10);
                check("misaligned", v.is_data ? o_d_misaligned : o_if_misaligned, v.exp_mis);
                check("latency", cyc, exp_lat);
                check("issued", issued, !v.exp_mis);
                if (!v.exp_mis)
                    check("resp_data", v.is_data ? o_d_resp_data : o_if_resp_data, v.exp_resp);
                done = 1'b1;
            end else begin
                if (phase == 0 && o_mem_req_valid) begin
                    issued = 1'b1;
                    phase  = 1;
                    cnt    = 0;
                end
                if (phase == 1) begin
                    check("req_valid", o_mem_req_valid, 1);
                    check("req_addr",  o_mem_req_addr, exp_addr);
                    check("req_we",    o_mem_req_we, v.is_data & v.we);
                    check("req_wstrb", o_mem_req_wstrb, v.exp_strb);
                    check("req_wdata", o_mem_req_wdata, v.exp_wdata);
                    if (cnt == v.rdy_dly) begin
                        i_mem_req_ready = 1'b1;
                        phase = 2;
                        cnt   = 0;
                    end else begin
                        cnt++;
                        if (v.spur) begin
                            i_mem_resp_valid = 1'b1;
                            i_mem_resp_rdata = 32'hBAD0BAD0;
                        end
                    end
                end else if (phase == 2) begin
                    check("req_dropped", o_mem_req_valid, 0);
                    if (cnt == v.resp_dly) begin
                        i_mem_resp_valid = 1'b1;
                        i_mem_resp_rdata = v.rdata;
                        phase = 3;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
        if (!done) check("timeout", 1, 0);
        drop_all();
        @(posedge clk); #1;
        check("no_dup", {o_if_resp_valid, o_d_resp_valid, o_mem_req_valid}, 0);
    endtask

    task automatic do_reset();
        drop_all();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    vec_t tbl[13];
    vec_t rv;
    logic ok;
    logic exp_d;

    initial begin
        i_if_req_addr  = 32'h0;
        i_d_req_we     = 1'b0;
        i_d_req_addr   = 32'h0;
        i_d_req_funct3 = 3'b000;
        i_d_req_wdata  = 32'h0;
        i_mem_resp_rdata = 32'h0;
        drop_all();
        rst_n = 1'b0;

        //            data we  addr         f3      wdata         rdata        rdy resp spur  mis  strb     wdata         resp
        tbl[0]  = '{1'b0, 1'b0, 32'h100, 3'b000, 32'h0,        32'h00500093, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h00500093};
        tbl[1]  = '{1'b1, 1'b1, 32'h203, 3'b000, 32'h123456AB, 32'h0,        0, 0, 1'b0, 1'b0, 4'b1000, 32'hABABABAB, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 32'h402, 3'b101, 32'h0,        32'hBEEF1234, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0000BEEF};
        tbl[3]  = '{1'b1, 1'b0, 32'h402, 3'b010, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[4]  = '{1'b1, 1'b1, 32'h010, 3'b010, 32'hCAFEF00D, 32'h0,        2, 0, 1'b1, 1'b0, 4'b1111, 32'hCAFEF00D, 32'h0};
        tbl[5]  = '{1'b0, 1'b0, 32'h102, 3'b000, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[6]  = '{1'b1, 1'b0, 32'h001, 3'b000, 32'h0,        32'h11223344, 0, 1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h00112233};
        tbl[7]  = '{1'b1, 1'b1, 32'h002, 3'b001, 32'hFFFF5678, 32'h0,        1, 0, 1'b0, 1'b0, 4'b1100, 32'h56785678, 32'h0};
        tbl[8]  = '{1'b1, 1'b1, 32'h001, 3'b001, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[9]  = '{1'b1, 1'b0, 32'h000, 3'b011, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[10] = '{1'b1, 1'b1, 32'h000, 3'b100, 32'h0,        32'h0,        0, 0, 1'b0, 1'b1, 4'b0000, 32'h0,        32'h0};
        tbl[11] = '{1'b1, 1'b0, 32'h000, 3'b001, 32'h0,        32'h8000ABCD, 1, 2, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h8000ABCD};
        tbl[12] = '{1'b1, 1'b0, 32'h003, 3'b100, 32'h0,        32'hDEADBEEF, 0, 0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h000000DE};

        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 13; i++) txn(tbl[i]);

        // Both requesters held: order must alternate DATA, FETCH, DATA.
        do_reset();
        i_if_req_valid = 1'b1;
        i_if_req_addr  = 32'h100;
        i_d_req_valid  = 1'b1;
        i_d_req_we     = 1'b1;
        i_d_req_addr   = 32'h42;
        i_d_req_funct3 = 3'b001;
        i_d_req_wdata  = 32'h0000BEEF;
        for (int g = 0; g < 3; g++) begin
            exp_d = (g != 1);
            ok = 1'b0;
            for (int k = 0; k < 10 && !ok; k++) begin
                @(posedge clk); #1;
                if (o_mem_req_valid) ok = 1'b1;
            end
            check("arb_req_seen", ok, 1);
            for (int k = 0; k < 6; k++) begin
                if (k > 0) begin
                    @(posedge clk); #1;
                end
                check("arb_valid", o_mem_req_valid, 1);
                check("arb_addr",  o_mem_req_addr, exp_d ? 32'h40 : 32'h100);
                check("arb_we",    o_mem_req_we, exp_d);
                check("arb_wstrb", o_mem_req_wstrb, exp_d ? 4'b1100 : 4'b0000);
                check("arb_wdata", o_mem_req_wdata, exp_d ? 32'hBEEFBEEF : 32'h0);
            end
            i_mem_req_ready = 1'b1;
            @(posedge clk); #1;
            i_mem_req_ready  = 1'b0;
            i_mem_resp_valid = 1'b1;
            i_mem_resp_rdata = $urandom;
            @(posedge clk); #1;
            i_mem_resp_valid = 1'b0;
            check("arb_pulse", {o_if_resp_valid, o_d_resp_valid}, exp_d ? 2'b01 : 2'b10);
        end
        drop_all();
        @(posedge clk); #1;
        check("arb_quiet", {o_if_resp_valid, o_d_resp_valid, o_mem_req_valid}, 0);

        // Reset while waiting for the memory response, then a stray response.
        i_if_req_valid = 1'b1;
        i_if_req_addr  = 32'h200;
        @(posedge clk); #1;
        check("rw_issue", o_mem_req_valid, 1);
        i_mem_req_ready = 1'b1;
        @(posedge clk); #1;
        i_mem_req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_zero("rw_reset");
        i_if_req_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        i_mem_resp_valid = 1'b1;
        i_mem_resp_rdata = 32'h12345678;
        @(posedge clk); #1;
        i_mem_resp_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rw_no_pulse", {o_if_resp_valid, o_d_resp_valid, o_mem_req_valid}, 0);
            @(posedge clk); #1;
        end
        txn(tbl[0]);

        for (int i = 0; i < 150; i++) begin
            rv.is_data  = 1'($urandom_range(0, 3) != 0);
            rv.we       = 1'($urandom_range(0, 1));
            rv.addr     = $urandom & 32'h0000_0FFF;
            rv.f3       = 3'($urandom_range(0, 7));
            rv.wdata    = $urandom;
            rv.rdata    = $urandom;
            rv.rdy_dly  = $urandom_range(0, 3);
            rv.resp_dly = $urandom_range(0, 3);
            rv.spur     = 1'($urandom_range(0, 1));
            txn(model(rv));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
